// File: rtl/bmc_soft_pipe_if.sv
// rtl/bmc_soft_pipe_if.sv - Handshake and data bundle between beat source, branch-metric unit and ACS sink
interface bmc_soft_pipe_if #(
    parameter int N         = 2,
    parameter int SOFT_W    = 3,
    parameter int BM_W      = SOFT_W + $clog2(N),
    parameter int FRAME_LEN = 64
);
    localparam int STEP_W = $clog2(FRAME_LEN);

    logic                     in_valid;
    logic                     in_ready;
    logic [N*SOFT_W-1:0]      rx_sym;
    logic [N-1:0]             punct_mask;
    logic                     out_valid;
    logic                     out_ready;
    logic [(2**N)*BM_W-1:0]   bm_out;
    logic                     out_last;
    logic [STEP_W-1:0]        out_step;

    modport master (
        output in_valid, rx_sym, punct_mask, out_ready,
        input  in_ready, out_valid, bm_out, out_last, out_step
    );

    modport slave (
        input  in_valid, rx_sym, punct_mask, out_ready,
        output in_ready, out_valid, bm_out, out_last, out_step
    );
endinterface

// File: rtl/bmc_soft_pipe.sv
// rtl/bmc_soft_pipe.sv - Pipelined rate-1/N soft branch-metric unit; define BMC_NORM_EN for min-normalised output stage
module bmc_soft_pipe #(
    parameter int N         = 2,
    parameter int SOFT_W    = 3,
    parameter int BM_W      = SOFT_W + $clog2(N),
    parameter int FRAME_LEN = 64
) (
    input  logic           clk,
    input  logic           rst,
    bmc_soft_pipe_if.slave bus
);
    localparam int NH     = 1 << N;
    localparam int STEP_W = $clog2(FRAME_LEN);
    localparam logic [SOFT_W-1:0] SYM_MAX   = {SOFT_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAME_LEN - 1);

    typedef logic [N-1:0][SOFT_W-1:0] dist_t;
    typedef logic [NH-1:0][BM_W-1:0]  bm_t;

    logic advance;
    logic accept;

    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

    logic              s1_valid_q, s1_valid_d;
    dist_t             s1_dist0_q, s1_dist0_d;
    dist_t             s1_dist1_q, s1_dist1_d;
    logic [STEP_W-1:0] s1_step_q,  s1_step_d;
    logic              s1_last_q,  s1_last_d;

    logic              s2_valid_q, s2_valid_d;
    bm_t               s2_bm_q,    s2_bm_d;
    logic [STEP_W-1:0] s2_step_q,  s2_step_d;
    logic              s2_last_q,  s2_last_d;

    logic [SOFT_W-1:0] sym;
    logic [BM_W-1:0]   sum;

    // Every stage moves together; nothing advances while the output beat is stalled.
    assign advance      = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && advance;
    assign bus.in_ready = advance;

    always_comb begin : s1_next
        step_cnt_d = step_cnt_q;
        s1_valid_d = s1_valid_q;
        s1_dist0_d = s1_dist0_q;
        s1_dist1_d = s1_dist1_q;
        s1_step_d  = s1_step_q;
        s1_last_d  = s1_last_q;
        sym        = '0;
        if (advance) begin
            s1_valid_d = accept;
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    sym = bus.rx_sym[i*SOFT_W +: SOFT_W];
                    // Erased symbols contribute nothing to either hypothesis polarity.
                    if (bus.punct_mask[i]) begin
                        s1_dist0_d[i] = '0;
                        s1_dist1_d[i] = '0;
                    end else begin
                        s1_dist0_d[i] = sym;
                        s1_dist1_d[i] = SYM_MAX - sym;
                    end
                end
                s1_step_d  = step_cnt_q;
                s1_last_d  = (step_cnt_q == STEP_LAST);
                step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin : s2_next
        s2_valid_d = s2_valid_q;
        s2_bm_d    = s2_bm_q;
        s2_step_d  = s2_step_q;
        s2_last_d  = s2_last_q;
        sum        = '0;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            s2_step_d  = s1_step_q;
            s2_last_d  = s1_last_q;
            for (int h = 0; h < NH; h++) begin
                sum = '0;
                for (int i = 0; i < N; i++) begin
                    sum = sum + ((((h >> i) & 1) != 0) ? BM_W'(s1_dist1_q[i])
                                                       : BM_W'(s1_dist0_q[i]));
                end
                s2_bm_d[h] = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_dist0_q <= '0;
            s1_dist1_q <= '0;
            s1_step_q  <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_bm_q    <= '0;
            s2_step_q  <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_dist0_q <= s1_dist0_d;
            s1_dist1_q <= s1_dist1_d;
            s1_step_q  <= s1_step_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_bm_q    <= s2_bm_d;
            s2_step_q  <= s2_step_d;
            s2_last_q  <= s2_last_d;
        end
    end

`ifdef BMC_NORM_EN
    logic              s3_valid_q, s3_valid_d;
    bm_t               s3_bm_q,    s3_bm_d;
    logic [STEP_W-1:0] s3_step_q,  s3_step_d;
    logic              s3_last_q,  s3_last_d;
    logic [BM_W-1:0]   min_bm;

    // Rebase so the best hypothesis reports 0, keeping ACS path metrics bounded.
    always_comb begin : s3_next
        s3_valid_d = s3_valid_q;
        s3_bm_d    = s3_bm_q;
        s3_step_d  = s3_step_q;
        s3_last_d  = s3_last_q;
        min_bm     = s2_bm_q[0];
        for (int h = 1; h < NH; h++) begin
            if (s2_bm_q[h] < min_bm) begin
                min_bm = s2_bm_q[h];
            end
        end
        if (advance) begin
            s3_valid_d = s2_valid_q;
            s3_step_d  = s2_step_q;
            s3_last_d  = s2_last_q;
            for (int h = 0; h < NH; h++) begin
                s3_bm_d[h] = s2_bm_q[h] - min_bm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_bm_q    <= '0;
            s3_step_q  <= '0;
            s3_last_q  <= 1'b0;
        end else begin
            s3_valid_q <= s3_valid_d;
            s3_bm_q    <= s3_bm_d;
            s3_step_q  <= s3_step_d;
            s3_last_q  <= s3_last_d;
        end
    end

    assign bus.out_valid = s3_valid_q;
    assign bus.bm_out    = s3_bm_q;
    assign bus.out_last  = s3_last_q;
    assign bus.out_step  = s3_step_q;
`else
    assign bus.out_valid = s2_valid_q;
    assign bus.bm_out    = s2_bm_q;
    assign bus.out_last  = s2_last_q;
    assign bus.out_step  = s2_step_q;
`endif
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// tb/tb_bmc_soft_pipe.sv - Scoreboard bench for bmc_soft_pipe with randomized beats and a reference metric model
`timescale 1ns/1ps
module tb_bmc_soft_pipe;
    localparam int N         = 2;
    localparam int SOFT_W    = 3;
    localparam int BM_W      = 4;
    localparam int FRAME_LEN = 4;
    localparam int STEP_W    = $clog2(FRAME_LEN);
    localparam int NH        = 1 << N;
    localparam int SYMS_W    = N * SOFT_W;
    localparam int BMS_W     = NH * BM_W;
    localparam int SMAX      = (1 << SOFT_W) - 1;
`ifdef BMC_NORM_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [BMS_W-1:0]  bm;
        logic [STEP_W-1:0] step;
        logic              last;
        int                cyc;
        bit                chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bmc_soft_pipe_if #(.N(N), .SOFT_W(SOFT_W), .BM_W(BM_W), .FRAME_LEN(FRAME_LEN)) bus ();

    bmc_soft_pipe #(.N(N), .SOFT_W(SOFT_W), .BM_W(BM_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t              sb[$];
    exp_t              push_e;
    exp_t              pop_e;
    int                n_chk = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                model_step = 0;
    bit                lat_mode = 0;
    bit                dir_en = 0;
    logic [BMS_W-1:0]  dir_exp = '0;
    bit                rand_done = 0;
    logic              stall_prev = 1'b0;
    logic [BMS_W-1:0]  prev_bm;
    logic [STEP_W-1:0] prev_step;
    logic              prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Distance of each symbol to each hypothesis bit, summed per hypothesis.
    function automatic logic [BMS_W-1:0] model(input logic [SYMS_W-1:0] s, input logic [N-1:0] m);
        int met[NH];
        int mn;
        int v;
        logic [BMS_W-1:0] r;
        for (int h = 0; h < NH; h++) begin
            met[h] = 0;
            for (int i = 0; i < N; i++) begin
                v = int'(s[i*SOFT_W +: SOFT_W]);
                if (!m[i]) met[h] += (((h >> i) & 1) != 0) ? (SMAX - v) : v;
            end
        end
        mn = met[0];
        for (int h = 1; h < NH; h++) if (met[h] < mn) mn = met[h];
`ifdef BMC_NORM_EN
        for (int h = 0; h < NH; h++) met[h] -= mn;
`endif
        r = '0;
        for (int h = 0; h < NH; h++) r[h*BM_W +: BM_W] = BM_W'(met[h]);
        return r;
    endfunction

    initial forever begin : stim_side
        @(negedge clk);
        if (rst) begin
            sb.delete();
            model_step = 0;
        end else if (bus.in_valid && bus.in_ready) begin
            push_e.bm      = dir_en ? dir_exp : model(bus.rx_sym, bus.punct_mask);
            push_e.step    = STEP_W'(model_step);
            push_e.last    = (model_step == FRAME_LEN - 1);
            push_e.cyc     = cyc;
            push_e.chk_lat = lat_mode;
            sb.push_back(push_e);
            model_step = (model_step + 1) % FRAME_LEN;
        end
    end

    initial forever begin : monitor
        @(negedge clk);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.out_ready) chk("in_ready_open", bus.in_ready, 1);
            if (bus.out_valid && !bus.out_ready) begin
                chk("in_ready_stall", bus.in_ready, 0);
                if (stall_prev) begin
                    chk("hold_bm", bus.bm_out, prev_bm);
                    chk("hold_step", bus.out_step, prev_step);
                    chk("hold_last", bus.out_last, prev_last);
                end
                stall_prev = 1'b1;
                prev_bm    = bus.bm_out;
                prev_step  = bus.out_step;
                prev_last  = bus.out_last;
            end else begin
                stall_prev = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("unexpected_beat", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    pop_e = sb.pop_front();
                    chk("bm_out", bus.bm_out, pop_e.bm);
                    chk("out_step", bus.out_step, pop_e.step);
                    chk("out_last", bus.out_last, pop_e.last);
                    if (pop_e.chk_lat) chk("latency", cyc - pop_e.cyc, LAT);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post_reset_checks();
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_bm_out", bus.bm_out, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_step", bus.out_step, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
        post_reset_checks();
    endtask

    task automatic issue(input logic [SYMS_W-1:0] s, input logic [N-1:0] m);
        int   guard;
        logic acc;
        guard = 0;
        bus.in_valid   = 1'b1;
        bus.rx_sym     = s;
        bus.punct_mask = m;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", guard);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic issue_dir(input logic [SYMS_W-1:0] s, input logic [N-1:0] m, input logic [BMS_W-1:0] e);
        dir_en  = 1;
        dir_exp = e;
        issue(s, m);
        dir_en  = 0;
        repeat (LAT + 1) tick();
    endtask

    task automatic rand_beat();
        logic [N-1:0] m;
        m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        issue(SYMS_W'($urandom), m);
    endtask

    initial begin : main
        int g;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.rx_sym     = '0;
        bus.punct_mask = '0;
        bus.out_ready  = 1'b1;
        do_reset(2);

        lat_mode = 1;
        issue_dir({3'd7, 3'd0}, 2'b00, {4'd7, 4'd0, 4'd14, 4'd7});
        issue_dir({3'd7, 3'd0}, 2'b10, {4'd7, 4'd0, 4'd7, 4'd0});
        issue_dir({3'd7, 3'd0}, 2'b11, '0);
`ifdef BMC_NORM_EN
        issue_dir({3'd2, 3'd2}, 2'b00, {4'd6, 4'd3, 4'd3, 4'd0});
`else
        issue_dir({3'd2, 3'd2}, 2'b00, {4'd10, 4'd7, 4'd7, 4'd4});
`endif

        // Six back-to-back beats starting at frame step 0.
        for (int k = 0; k < 6; k++) rand_beat();
        repeat (LAT + 2) tick();
        lat_mode = 0;

        fork
            begin
                for (int k = 0; k < 8; k++) rand_beat();
            end
            begin
                repeat (3) tick();
                bus.out_ready = 1'b0;
                repeat (3) tick();
                bus.out_ready = 1'b1;
            end
        join
        repeat (LAT + 4) tick();

        // Reset with two beats in flight, plus a beat offered during reset.
        bus.out_ready = 1'b1;
        issue({3'd5, 3'd1}, 2'b00);
        bus.out_ready = 1'b0;
        issue({3'd3, 3'd6}, 2'b01);
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.rx_sym     = {3'd4, 3'd4};
        bus.punct_mask = 2'b00;
        tick();
        bus.out_ready = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        post_reset_checks();
        lat_mode = 1;
        rand_beat();
        rand_beat();
        repeat (LAT + 2) tick();
        lat_mode = 0;

        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    rand_beat();
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                bus.out_ready = 1'b1;
            end
        join

        g = 0;
        while (sb.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
